// File: rtl/rtc_write_seq_pkg.sv
// Shared types and constants for the RTC write sequencer: FSM states, default
// bus timing, the transfer-command address and RTC register addresses.
package rtc_write_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SETUP,
        S_A_STROBE,
        S_A_HOLD,
        S_D_SETUP,
        S_D_STROBE,
        S_D_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    localparam int unsigned T_SETUP_DEF  = 2;
    localparam int unsigned T_PULSE_DEF  = 4;
    localparam int unsigned T_HOLD_DEF   = 2;
    localparam int unsigned T_GAP_DEF    = 3;
    localparam logic [7:0]  CMD_ADDR_DEF = 8'hF1;
    localparam logic [7:0]  ADDR_HORA    = 8'h23;

    // Registered pin image; ordering matches the reset/idle defaults below.
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       cs_n;
        logic       wr_n;
        logic       ad_sel;
        logic       ad_oe;
        logic [7:0] ad_out;
    } bus_out_t;

    localparam bus_out_t BUS_IDLE = '{busy: 1'b0, done: 1'b0, cs_n: 1'b1, wr_n: 1'b1,
                                      ad_sel: 1'b0, ad_oe: 1'b0, ad_out: 8'h00};

    // Timer terminal count for a phase of n cycles (n in 1..15).
    function automatic logic [3:0] len_m1(input int unsigned n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/rtc_write_seq_if.sv
// Request side plus RTC pin side of the write sequencer, grouped as one bundle.
interface rtc_write_seq_if;
    logic       start;
    logic [7:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic       ad_oe;
    logic [7:0] ad_out;

    modport master (output start, addr, data,
                    input  busy, done, cs_n, rd_n, wr_n, ad_sel, ad_oe, ad_out);
    modport slave  (input  start, addr, data,
                    output busy, done, cs_n, rd_n, wr_n, ad_sel, ad_oe, ad_out);
endinterface

// File: rtl/rtc_write_seq_phase_timer.sv
// 4-bit loadable down-counter shared by every bus phase; zero marks the last
// cycle of the current phase.
module rtc_write_seq_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] len,
    output logic       zero
);
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)             cnt <= 4'd0;
        else if (load)       cnt <= len;
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == 4'd0);
endmodule

// File: rtl/rtc_write_seq.sv
// Intel-style multiplexed-bus write sequencer for the external RTC.
// Optional macro TRANSFER_CMD_EN appends a gap and a CMD_ADDR/CMD_ADDR command write.
module rtc_write_seq
    import rtc_write_seq_pkg::*;
#(
    parameter int unsigned T_SETUP  = T_SETUP_DEF,
    parameter int unsigned T_PULSE  = T_PULSE_DEF,
    parameter int unsigned T_HOLD   = T_HOLD_DEF,
    parameter int unsigned T_GAP    = T_GAP_DEF,
    parameter logic [7:0]  CMD_ADDR = CMD_ADDR_DEF
) (
    input  logic           clk,
    input  logic           rst,
    rtc_write_seq_if.slave bus
);
    state_t     state_q, state_d;
    logic       cmd_q, cmd_d;
    logic [7:0] addr_q, data_q;
    logic [7:0] a_val, d_val;
    logic       accept;
    logic       tmr_load, tmr_zero;
    logic [3:0] tmr_len;
    bus_out_t   out_q, out_d;

    rtc_write_seq_phase_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .len  (tmr_len),
        .zero (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    state_d = S_A_SETUP;
                    cmd_d   = 1'b0;
                    accept  = 1'b1;
                end
            end
            S_A_SETUP:  if (tmr_zero) state_d = S_A_STROBE;
            S_A_STROBE: if (tmr_zero) state_d = S_A_HOLD;
            S_A_HOLD:   if (tmr_zero) state_d = S_D_SETUP;
            S_D_SETUP:  if (tmr_zero) state_d = S_D_STROBE;
            S_D_STROBE: if (tmr_zero) state_d = S_D_HOLD;
            S_D_HOLD: if (tmr_zero) begin
`ifdef TRANSFER_CMD_EN
                state_d = cmd_q ? S_DONE : S_GAP;
`else
                state_d = S_DONE;
`endif
            end
            S_GAP: if (tmr_zero) begin
                state_d = S_A_SETUP;
                cmd_d   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every phase entry is a state change, so the timer loads exactly then.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_len  = 4'd0;
        case (state_d)
            S_A_SETUP, S_D_SETUP:   tmr_len = len_m1(T_SETUP);
            S_A_STROBE, S_D_STROBE: tmr_len = len_m1(T_PULSE);
            S_A_HOLD, S_D_HOLD:     tmr_len = len_m1(T_HOLD);
            S_GAP:                  tmr_len = len_m1(T_GAP);
            default:                tmr_len = 4'd0;
        endcase
    end

    // Pins are registered from the next state so they change cleanly with it.
    assign a_val = cmd_d ? CMD_ADDR : (accept ? bus.addr : addr_q);
    assign d_val = cmd_d ? CMD_ADDR : (accept ? bus.data : data_q);

    always_comb begin
        out_d = BUS_IDLE;
        case (state_d)
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                out_d.busy   = 1'b1;
                out_d.cs_n   = 1'b0;
                out_d.ad_oe  = 1'b1;
                out_d.ad_out = a_val;
                out_d.wr_n   = (state_d != S_A_STROBE);
            end
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                out_d.busy   = 1'b1;
                out_d.cs_n   = 1'b0;
                out_d.ad_oe  = 1'b1;
                out_d.ad_sel = 1'b1;
                out_d.ad_out = d_val;
                out_d.wr_n   = (state_d != S_D_STROBE);
            end
            S_GAP:   out_d.busy = 1'b1;
            S_DONE:  out_d.done = 1'b1;
            default: out_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            out_q   <= BUS_IDLE;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            out_q   <= out_d;
            if (accept) begin
                addr_q <= bus.addr;
                data_q <= bus.data;
            end
        end
    end

    assign bus.busy   = out_q.busy;
    assign bus.done   = out_q.done;
    assign bus.cs_n   = out_q.cs_n;
    assign bus.rd_n   = 1'b1;
    assign bus.wr_n   = out_q.wr_n;
    assign bus.ad_sel = out_q.ad_sel;
    assign bus.ad_oe  = out_q.ad_oe;
    assign bus.ad_out = out_q.ad_out;
endmodule

// File: tb/tb_rtc_write_seq.sv
// Bench for rtc_write_seq: per-cycle comparison against a timeline model plus
// scenario table (done count, strobe cycles) and random traffic.
module tb_rtc_write_seq;
    localparam int TS = 2, TP = 4, TH = 2, TG = 3;
    localparam logic [7:0] CMD = 8'hF1;
    localparam int L = TS + TP + TH;
`ifdef TRANSFER_CMD_EN
    localparam int BUSY = 4 * L + TG;
    localparam int WPT  = 2 * TP * 2;
`else
    localparam int BUSY = 2 * L;
    localparam int WPT  = 2 * TP;
`endif

    typedef struct packed {
        logic       busy, done, cs_n, rd_n, wr_n, ad_sel, ad_oe;
        logic [7:0] ad_out;
    } obs_t;

    typedef struct {
        int s2, rst_at, s3;     // offsets from first start, -1 = none
        int exp_done, exp_wr;
    } scen_t;

    localparam obs_t IDLE = '{busy: 0, done: 0, cs_n: 1, rd_n: 1, wr_n: 1,
                              ad_sel: 0, ad_oe: 0, ad_out: 8'h00};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rtc_write_seq_if bus ();

    rtc_write_seq #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG), .CMD_ADDR(CMD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0, miscompares = 0;
    int done_cnt, wr_cnt;
    bit act = 0;
    int ks = 0, cyc = 0;
    logic [7:0] la, ld;

    // Expected pins at cycle offset off after a start presented at offset 0.
    function automatic obs_t expect_at(input int off, input logic [7:0] a, input logic [7:0] d);
        obs_t e;
        int t, half, w;
        logic [7:0] av, dv;
        e = IDLE;
        if (off == BUSY + 1) e.done = 1'b1;
        else if (off >= 1 && off <= BUSY) begin
            t = off - 1;
            av = a;
            dv = d;
            e.busy = 1'b1;
            if (t >= 2 * L) begin
                if (t < 2 * L + TG) return e;
                t = t - 2 * L - TG;
                av = CMD;
                dv = CMD;
            end
            half = t / L;
            w = t % L;
            e.cs_n = 1'b0;
            e.ad_oe = 1'b1;
            e.ad_sel = (half == 1);
            e.ad_out = (half == 1) ? dv : av;
            e.wr_n = !(w >= TS && w < TS + TP);
        end
        return e;
    endfunction

    task automatic step(input logic st, input logic [7:0] a, input logic [7:0] d, input logic r);
        obs_t e, g;
        @(negedge clk);
        bus.start = st;
        bus.addr = a;
        bus.data = d;
        rst = r;
        @(posedge clk);
        if (r) act = 0;
        else if (st && !(act && cyc - ks >= 1 && cyc - ks <= BUSY)) begin
            act = 1;
            ks = cyc;
            la = a;
            ld = d;
        end
        cyc++;
        #1;
        e = act ? expect_at(cyc - ks, la, ld) : IDLE;
        g = '{bus.busy, bus.done, bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_sel, bus.ad_oe, bus.ad_out};
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL pins cyc=%0d off=%0d: got busy%b done%b cs%b rd%b wr%b sel%b oe%b ad%h want busy%b done%b cs%b rd%b wr%b sel%b oe%b ad%h",
                     cyc, cyc - ks, g.busy, g.done, g.cs_n, g.rd_n, g.wr_n, g.ad_sel, g.ad_oe, g.ad_out,
                     e.busy, e.done, e.cs_n, e.rd_n, e.wr_n, e.ad_sel, e.ad_oe, e.ad_out);
        end
        if (g.done === 1'b1) done_cnt++;
        if (g.wr_n === 1'b0) wr_cnt++;
    endtask

    scen_t scen[5];

    initial begin
        scen[0] = '{s2: -1,       rst_at: -1, s3: -1, exp_done: 1, exp_wr: WPT};
        scen[1] = '{s2: 5,        rst_at: -1, s3: -1, exp_done: 1, exp_wr: WPT};
        scen[2] = '{s2: -1,       rst_at: 10, s3: 13, exp_done: 1, exp_wr: TP + WPT};
        scen[3] = '{s2: BUSY + 1, rst_at: -1, s3: -1, exp_done: 2, exp_wr: 2 * WPT};
        scen[4] = '{s2: BUSY,     rst_at: -1, s3: -1, exp_done: 1, exp_wr: WPT};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.addr = 8'h00;
        bus.data = 8'h00;
        step(0, 8'h00, 8'h00, 1);
        step(0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 8'h00, 0);

        for (int i = 0; i < 5; i++) begin
            done_cnt = 0;
            wr_cnt = 0;
            for (int c = 0; c < 2 * BUSY + 8; c++) begin
                logic st, r;
                logic [7:0] a, d;
                st = (c == 0) || (c == scen[i].s2) || (c == scen[i].s3);
                r  = (c == scen[i].rst_at);
                a  = (c == 0) ? rtc_write_seq_pkg::ADDR_HORA : 8'h45;
                d  = (c == 0) ? 8'h12 : ((c == scen[i].s2) ? 8'h99 : 8'h34);
                step(st, a, d, r);
            end
            vectors++;
            if (done_cnt != scen[i].exp_done) begin
                miscompares++;
                $display("FAIL scen%0d done pulses: got %0d want %0d", i, done_cnt, scen[i].exp_done);
            end
            vectors++;
            if (wr_cnt != scen[i].exp_wr) begin
                miscompares++;
                $display("FAIL scen%0d wr_n low cycles: got %0d want %0d", i, wr_cnt, scen[i].exp_wr);
            end
        end

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 7) == 0, 8'($urandom), 8'($urandom), $urandom_range(0, 99) == 0);
        for (int i = 0; i < BUSY + 4; i++) step(0, 8'h00, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
